// File: rtl/uart_baud_gen.sv
// Fractional-N baud tick generator: RX oversample/mid-bit strobes and a TX bit strobe.
// Fractional accumulation is compiled in only when UART_BAUD_FRAC_EN is defined.
module uart_baud_gen #(
    parameter int unsigned CLK_HZ     = 125000000,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DIV_WIDTH  = 16,
    parameter int unsigned FRAC_WIDTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    input  logic                  i_div_wr,
    input  logic [DIV_WIDTH-1:0]  i_div_int,
    input  logic [FRAC_WIDTH-1:0] i_div_frac,
    input  logic                  i_rx_resync,
    output logic                  o_rxclk_en,
    output logic                  o_rx_mid,
    output logic                  o_txclk_en,
    output logic [DIV_WIDTH-1:0]  o_div_int,
    output logic [FRAC_WIDTH-1:0] o_div_frac
);

    localparam int SUB_W = $clog2(OVERSAMPLE);
    localparam logic [63:0] DEF_DIV_L =
        (64'(CLK_HZ) << FRAC_WIDTH) / (64'(BAUD_RATE) * 64'(OVERSAMPLE));
    localparam logic [DIV_WIDTH-1:0] RST_INT  = DEF_DIV_L[FRAC_WIDTH +: DIV_WIDTH];
    localparam logic [SUB_W-1:0]     SUB_MID  = SUB_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SUB_W-1:0]     SUB_LAST = SUB_W'(OVERSAMPLE - 1);

    logic [DIV_WIDTH-1:0] div_int_q;
    logic [DIV_WIDTH-1:0] eff_d;
    logic [DIV_WIDTH-1:0] rx_cnt;
    logic [DIV_WIDTH-1:0] tx_cnt;
    logic [DIV_WIDTH-1:0] rx_last;
    logic [DIV_WIDTH-1:0] tx_last;
    logic [SUB_W-1:0]     rx_sub;
    logic [SUB_W-1:0]     tx_sub;
    logic                 rx_carry;
    logic                 tx_carry;
    logic                 rx_clear;
    logic                 tx_clear;
    logic                 rx_tc;
    logic                 tx_tc;

    // A divisor below 2 would make the counter terminate every cycle; clamp it.
    assign eff_d    = (div_int_q < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : div_int_q;
    assign rx_last  = eff_d - DIV_WIDTH'(1) + DIV_WIDTH'(rx_carry);
    assign tx_last  = eff_d - DIV_WIDTH'(1) + DIV_WIDTH'(tx_carry);
    assign rx_tc    = (rx_cnt == rx_last);
    assign tx_tc    = (tx_cnt == tx_last);
    assign rx_clear = i_div_wr | ~i_en | i_rx_resync;
    assign tx_clear = i_div_wr | ~i_en;
    assign o_div_int = div_int_q;

`ifdef UART_BAUD_FRAC_EN
    localparam logic [FRAC_WIDTH-1:0] RST_FRAC = DEF_DIV_L[FRAC_WIDTH-1:0];

    logic [FRAC_WIDTH-1:0] div_frac_q;
    logic [FRAC_WIDTH-1:0] rx_acc;
    logic [FRAC_WIDTH-1:0] tx_acc;
    logic [FRAC_WIDTH:0]   rx_sum;
    logic [FRAC_WIDTH:0]   tx_sum;

    assign rx_sum     = {1'b0, rx_acc} + {1'b0, div_frac_q};
    assign tx_sum     = {1'b0, tx_acc} + {1'b0, div_frac_q};
    assign o_div_frac = div_frac_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            div_frac_q <= RST_FRAC;
        end else if (i_div_wr) begin
            div_frac_q <= i_div_frac;
        end
    end

    // The carry out of each add stretches the following period by one cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rx_acc   <= '0;
            rx_carry <= 1'b0;
        end else if (rx_clear) begin
            rx_acc   <= '0;
            rx_carry <= 1'b0;
        end else if (rx_tc) begin
            rx_acc   <= rx_sum[FRAC_WIDTH-1:0];
            rx_carry <= rx_sum[FRAC_WIDTH];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tx_acc   <= '0;
            tx_carry <= 1'b0;
        end else if (tx_clear) begin
            tx_acc   <= '0;
            tx_carry <= 1'b0;
        end else if (tx_tc) begin
            tx_acc   <= tx_sum[FRAC_WIDTH-1:0];
            tx_carry <= tx_sum[FRAC_WIDTH];
        end
    end
`else
    logic unused_frac;

    assign unused_frac = ^i_div_frac;
    assign rx_carry    = 1'b0;
    assign tx_carry    = 1'b0;
    assign o_div_frac  = '0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            div_int_q <= RST_INT;
        end else if (i_div_wr) begin
            div_int_q <= i_div_int;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rx_cnt     <= '0;
            rx_sub     <= '0;
            o_rxclk_en <= 1'b0;
            o_rx_mid   <= 1'b0;
        end else begin
            o_rxclk_en <= 1'b0;
            o_rx_mid   <= 1'b0;
            if (rx_clear) begin
                rx_cnt <= '0;
                rx_sub <= '0;
            end else if (rx_tc) begin
                rx_cnt     <= '0;
                rx_sub     <= rx_sub + SUB_W'(1);
                o_rxclk_en <= 1'b1;
                o_rx_mid   <= (rx_sub == SUB_MID);
            end else begin
                rx_cnt <= rx_cnt + DIV_WIDTH'(1);
            end
        end
    end

    // TX runs its own prescaler so an RX resync never disturbs the TX bit timing.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tx_cnt     <= '0;
            tx_sub     <= '0;
            o_txclk_en <= 1'b0;
        end else begin
            o_txclk_en <= 1'b0;
            if (tx_clear) begin
                tx_cnt <= '0;
                tx_sub <= '0;
            end else if (tx_tc) begin
                tx_cnt     <= '0;
                tx_sub     <= tx_sub + SUB_W'(1);
                o_txclk_en <= (tx_sub == SUB_LAST);
            end else begin
                tx_cnt <= tx_cnt + DIV_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_baud_gen.sv
// Self-checking bench for uart_baud_gen: randomized stimulus against a closed-form tick-time model.
// Follows the DUT build: the fractional model is active only when UART_BAUD_FRAC_EN is defined.
module tb_uart_baud_gen;

    localparam int DW      = 16;
    localparam int FW      = 4;
    localparam int OS      = 16;
    localparam int DEF_INT = 67;
`ifdef UART_BAUD_FRAC_EN
    localparam int DEF_FRAC = 13;
    localparam bit FRAC_ON  = 1'b1;
`else
    localparam int DEF_FRAC = 0;
    localparam bit FRAC_ON  = 1'b0;
`endif

    logic          clk       = 1'b0;
    logic          rst       = 1'b0;
    logic          en        = 1'b1;
    logic          div_wr    = 1'b0;
    logic [DW-1:0] div_int   = '0;
    logic [FW-1:0] div_frac  = '0;
    logic          rx_resync = 1'b0;
    logic          rxclk_en;
    logic          rx_mid;
    logic          txclk_en;
    logic [DW-1:0] rd_int;
    logic [FW-1:0] rd_frac;

    int vectors     = 0;
    int miscompares = 0;

    // Model state: edge count, restart edge and next tick index per prescaler, active divisor.
    int       cyc      = 0;
    int       rx_r     = 0;
    int       tx_r     = 0;
    int       rx_n     = 1;
    int       tx_n     = 1;
    int       raw_int  = DEF_INT;
    int       raw_frac = DEF_FRAC;
    logic [2:0] exp_vec = 3'b000;

    uart_baud_gen dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_en        (en),
        .i_div_wr    (div_wr),
        .i_div_int   (div_int),
        .i_div_frac  (div_frac),
        .i_rx_resync (rx_resync),
        .o_rxclk_en  (rxclk_en),
        .o_rx_mid    (rx_mid),
        .o_txclk_en  (txclk_en),
        .o_div_int   (rd_int),
        .o_div_frac  (rd_frac)
    );

    always #4 clk = ~clk;

    // Tick n after a restart lands n*D + floor((n-1)*F / 2^FW) edges later.
    function automatic int tick_time(int n);
        int d;
        d = (raw_int < 2) ? 2 : raw_int;
        return n * d + (((n - 1) * raw_frac) >> FW);
    endfunction

    function automatic bit rx_tc_next();
        return (cyc + 1 - rx_r) == tick_time(rx_n);
    endfunction

    task automatic step();
        @(posedge clk);
        cyc++;
        exp_vec = 3'b000;
        if (rst) begin
            raw_int  = DEF_INT;
            raw_frac = DEF_FRAC;
            rx_r = cyc; rx_n = 1; tx_r = cyc; tx_n = 1;
        end else if (div_wr || !en) begin
            if (div_wr) begin
                raw_int  = int'(div_int);
                raw_frac = FRAC_ON ? int'(div_frac) : 0;
            end
            rx_r = cyc; rx_n = 1; tx_r = cyc; tx_n = 1;
        end else begin
            if (rx_resync) begin
                rx_r = cyc; rx_n = 1;
            end else if (cyc - rx_r == tick_time(rx_n)) begin
                exp_vec[2] = 1'b1;
                exp_vec[1] = (rx_n % OS == OS / 2);
                rx_n++;
            end
            if (cyc - tx_r == tick_time(tx_n)) begin
                exp_vec[0] = (tx_n % OS == 0);
                tx_n++;
            end
        end
        @(negedge clk);
    endtask

    task automatic write_div(input int d, input int f);
        div_int  = DW'(d);
        div_frac = FW'(f);
        div_wr   = 1'b1;
        step();
        div_wr   = 1'b0;
    endtask

    task automatic test_reset();
        int rx_cnt;
        int tx_cnt;
        en = 1'b1;
        #1 rst = 1'b1;
        #1;
        vectors++;
        if ({rxclk_en, rx_mid, txclk_en} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL reset_strobes got %b expected 000", {rxclk_en, rx_mid, txclk_en});
        end
        vectors++;
        if (rd_int !== DW'(DEF_INT) || rd_frac !== FW'(DEF_FRAC)) begin
            miscompares++;
            $display("[TB] FAIL reset_div got %0d/%0d expected %0d/%0d", rd_int, rd_frac, DEF_INT, DEF_FRAC);
        end
        step();
        step();
        rst = 1'b0;
        rx_cnt = 0;
        tx_cnt = 0;
        for (int i = 0; i < 1085; i++) begin
            step();
            vectors++;
            if ({rxclk_en, rx_mid, txclk_en} !== exp_vec) begin
                miscompares++;
                $display("[TB] FAIL default_run cyc=%0d got %b expected %b", cyc, {rxclk_en, rx_mid, txclk_en}, exp_vec);
            end
            rx_cnt += int'(rxclk_en);
            tx_cnt += int'(txclk_en);
        end
        vectors++;
        if (rx_cnt != 16 || tx_cnt != 1) begin
            miscompares++;
            $display("[TB] FAIL default_counts got rx=%0d tx=%0d expected rx=16 tx=1", rx_cnt, tx_cnt);
        end
    endtask

    task automatic test_min_divisor();
        int w;
        int first_rx;
        int last_tx;
        write_div(2, 0);
        w = cyc;
        first_rx = -1;
        last_tx = -1;
        vectors++;
        if ({rxclk_en, rx_mid, txclk_en} !== 3'b000 || rd_int !== DW'(2) || rd_frac !== FW'(0)) begin
            miscompares++;
            $display("[TB] FAIL write_cycle got strobes=%b div=%0d/%0d expected 000 2/0",
                     {rxclk_en, rx_mid, txclk_en}, rd_int, rd_frac);
        end
        for (int i = 0; i < 100; i++) begin
            step();
            vectors++;
            if ({rxclk_en, rx_mid, txclk_en} !== exp_vec) begin
                miscompares++;
                $display("[TB] FAIL min_div cyc=%0d got %b expected %b", cyc, {rxclk_en, rx_mid, txclk_en}, exp_vec);
            end
            if (rxclk_en && first_rx < 0) first_rx = cyc - w;
            if (txclk_en) begin
                if (last_tx >= 0) begin
                    vectors++;
                    if (cyc - last_tx != 32) begin
                        miscompares++;
                        $display("[TB] FAIL min_div_tx_spacing got %0d expected 32", cyc - last_tx);
                    end
                end
                last_tx = cyc;
            end
        end
        vectors++;
        if (first_rx != 2) begin
            miscompares++;
            $display("[TB] FAIL min_div_first_rx got %0d expected 2", first_rx);
        end
    endtask

    task automatic test_clamp();
        int f;
        for (int d = 0; d < 2; d++) begin
            f = int'($urandom_range(0, 15));
            write_div(d, f);
            vectors++;
            if (rd_int !== DW'(d) || rd_frac !== FW'(FRAC_ON ? f : 0)) begin
                miscompares++;
                $display("[TB] FAIL clamp_readback got %0d/%0d expected %0d/%0d", rd_int, rd_frac, d, FRAC_ON ? f : 0);
            end
            for (int i = 0; i < 70; i++) begin
                step();
                vectors++;
                if ({rxclk_en, rx_mid, txclk_en} !== exp_vec) begin
                    miscompares++;
                    $display("[TB] FAIL clamp d=%0d cyc=%0d got %b expected %b", d, cyc, {rxclk_en, rx_mid, txclk_en}, exp_vec);
                end
            end
        end
    endtask

    task automatic test_resync();
        int k;
        int t0;
        int first_rx;
        int first_mid;
        int last_tx;
        write_div(10, 0);
        k = 10 * int'($urandom_range(1, 3)) + int'($urandom_range(3, 7));
        for (int i = 0; i < k; i++) step();
        rx_resync = 1'b1;
        step();
        rx_resync = 1'b0;
        t0 = cyc;
        first_rx = -1;
        first_mid = -1;
        last_tx = -1;
        for (int i = 0; i < 400; i++) begin
            step();
            vectors++;
            if ({rxclk_en, rx_mid, txclk_en} !== exp_vec) begin
                miscompares++;
                $display("[TB] FAIL resync cyc=%0d got %b expected %b", cyc, {rxclk_en, rx_mid, txclk_en}, exp_vec);
            end
            if (rxclk_en && first_rx < 0) first_rx = cyc - t0;
            if (rx_mid && first_mid < 0) first_mid = cyc - t0;
            if (txclk_en) begin
                if (last_tx >= 0) begin
                    vectors++;
                    if (cyc - last_tx != 160) begin
                        miscompares++;
                        $display("[TB] FAIL resync_tx_spacing got %0d expected 160", cyc - last_tx);
                    end
                end
                last_tx = cyc;
            end
        end
        vectors++;
        if (first_rx != 10 || first_mid != 80) begin
            miscompares++;
            $display("[TB] FAIL resync_first got rx=%0d mid=%0d expected rx=10 mid=80", first_rx, first_mid);
        end
    endtask

    task automatic test_collision();
        bit found;
        write_div(int'($urandom_range(3, 12)), int'($urandom_range(0, 15)));
        for (int pass = 0; pass < 2; pass++) begin
            found = 1'b0;
            for (int i = 0; i < 100 && !found; i++) begin
                if (rx_tc_next()) begin
                    found = 1'b1;
                end else begin
                    step();
                    vectors++;
                    if ({rxclk_en, rx_mid, txclk_en} !== exp_vec) begin
                        miscompares++;
                        $display("[TB] FAIL collision_lead cyc=%0d got %b expected %b", cyc, {rxclk_en, rx_mid, txclk_en}, exp_vec);
                    end
                end
            end
            vectors++;
            if (!found) begin
                miscompares++;
                $display("[TB] FAIL collision_tc_search got none expected terminal count within 100 cycles");
            end
            rx_resync = 1'b1;
            if (pass == 0) begin
                div_int  = DW'($urandom_range(3, 12));
                div_frac = FW'($urandom_range(0, 15));
                div_wr   = 1'b1;
            end
            step();
            rx_resync = 1'b0;
            div_wr    = 1'b0;
            vectors++;
            if ({rxclk_en, rx_mid} !== 2'b00 || (pass == 0 && txclk_en !== 1'b0)) begin
                miscompares++;
                $display("[TB] FAIL collision_suppress pass=%0d got %b expected no rx tick", pass, {rxclk_en, rx_mid, txclk_en});
            end
            for (int i = 0; i < 200; i++) begin
                step();
                vectors++;
                if ({rxclk_en, rx_mid, txclk_en} !== exp_vec) begin
                    miscompares++;
                    $display("[TB] FAIL collision_after cyc=%0d got %b expected %b", cyc, {rxclk_en, rx_mid, txclk_en}, exp_vec);
                end
            end
        end
    endtask

    task automatic test_random();
        int d;
        int f;
        for (int r = 0; r < 6; r++) begin
            d = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 1)) : int'($urandom_range(2, 30));
            f = int'($urandom_range(0, 15));
            write_div(d, f);
            vectors++;
            if (rd_int !== DW'(d) || rd_frac !== FW'(FRAC_ON ? f : 0)) begin
                miscompares++;
                $display("[TB] FAIL random_readback got %0d/%0d expected %0d/%0d", rd_int, rd_frac, d, FRAC_ON ? f : 0);
            end
            for (int i = 0; i < 300; i++) begin
                rx_resync = ($urandom_range(0, 49) == 0);
                step();
                vectors++;
                if ({rxclk_en, rx_mid, txclk_en} !== exp_vec) begin
                    miscompares++;
                    $display("[TB] FAIL random d=%0d f=%0d cyc=%0d got %b expected %b",
                             d, f, cyc, {rxclk_en, rx_mid, txclk_en}, exp_vec);
                end
            end
            rx_resync = 1'b0;
        end
    endtask

    task automatic test_enable_reset();
        int ticks;
        int t0;
        int first_rx;
        write_div(5, int'($urandom_range(0, 15)));
        for (int i = 0; i < 30; i++) step();
        en = 1'b0;
        ticks = 0;
        for (int i = 0; i < 50; i++) begin
            if (i == 20) begin
                div_int = DW'(7);
                div_wr  = 1'b1;
            end
            step();
            div_wr = 1'b0;
            vectors++;
            if ({rxclk_en, rx_mid, txclk_en} !== exp_vec) begin
                miscompares++;
                $display("[TB] FAIL disabled cyc=%0d got %b expected %b", cyc, {rxclk_en, rx_mid, txclk_en}, exp_vec);
            end
            ticks += int'(rxclk_en | txclk_en | rx_mid);
        end
        vectors++;
        if (ticks != 0 || rd_int !== DW'(7)) begin
            miscompares++;
            $display("[TB] FAIL disabled_summary got ticks=%0d div=%0d expected ticks=0 div=7", ticks, rd_int);
        end
        en = 1'b1;
        t0 = cyc;
        first_rx = -1;
        for (int i = 0; i < 100; i++) begin
            step();
            vectors++;
            if ({rxclk_en, rx_mid, txclk_en} !== exp_vec) begin
                miscompares++;
                $display("[TB] FAIL enable cyc=%0d got %b expected %b", cyc, {rxclk_en, rx_mid, txclk_en}, exp_vec);
            end
            if (rxclk_en && first_rx < 0) first_rx = cyc - t0;
        end
        vectors++;
        if (first_rx != 7) begin
            miscompares++;
            $display("[TB] FAIL enable_first_rx got %0d expected 7", first_rx);
        end
        for (int i = 0; i < int'($urandom_range(1, 20)); i++) step();
        #1 rst = 1'b1;
        #1;
        vectors++;
        if ({rxclk_en, rx_mid, txclk_en} !== 3'b000 || rd_int !== DW'(DEF_INT) || rd_frac !== FW'(DEF_FRAC)) begin
            miscompares++;
            $display("[TB] FAIL midrun_reset got strobes=%b div=%0d/%0d expected 000 %0d/%0d",
                     {rxclk_en, rx_mid, txclk_en}, rd_int, rd_frac, DEF_INT, DEF_FRAC);
        end
        step();
        step();
        rst = 1'b0;
        t0 = cyc;
        first_rx = -1;
        for (int i = 0; i < 200; i++) begin
            step();
            vectors++;
            if ({rxclk_en, rx_mid, txclk_en} !== exp_vec) begin
                miscompares++;
                $display("[TB] FAIL post_reset cyc=%0d got %b expected %b", cyc, {rxclk_en, rx_mid, txclk_en}, exp_vec);
            end
            if (rxclk_en && first_rx < 0) first_rx = cyc - t0;
        end
        vectors++;
        if (first_rx != 67) begin
            miscompares++;
            $display("[TB] FAIL post_reset_first_rx got %0d expected 67", first_rx);
        end
    endtask

    initial begin
        test_reset();
        test_min_divisor();
        test_clamp();
        test_resync();
        test_collision();
        test_random();
        test_enable_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
